// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg
//   Shared definitions for the RV32I load/store unit memory initiator:
//   funct3 encodings, the LSU state type and lane-width constants.
//   Optional feature macro used by importers: LSU_MISALIGN_TRAP_EN.
package riscv_lsu_pkg;

    // RV32I load/store funct3 encodings (stores use only B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Lane widths in bits
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_RMW_RD    = 3'd3,
        ST_RMW_MERGE = 3'd4,
        ST_RMW_WR    = 3'd5,
        ST_DONE      = 3'd6
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_load_align.sv
// lsu_load_align
//   Combinational load lane extraction and sign/zero extension.
//   Ports:
//     word_i    - full 32-bit word read from memory
//     addr_lo_i - byte address bits [1:0]
//     funct3_i  - RV32I load funct3
//     data_o    - extended 32-bit load result
//   Halfword lane uses addr_lo_i[1] only; word loads return the word as is.
module lsu_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [2:0]        funct3_i,
    output logic [WORD_W-1:0] data_o
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;
    logic              sign_ext;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: BYTE_W];
        half_sel = word_i[{addr_lo_i[1], 4'b0000} +: HALF_W];
        // funct3[2] set marks the unsigned variants (LBU/LHU)
        sign_ext = ~funct3_i[2];
        case (funct3_i[1:0])
            2'b00:   data_o = {{(WORD_W-BYTE_W){sign_ext & byte_sel[BYTE_W-1]}}, byte_sel};
            2'b01:   data_o = {{(WORD_W-HALF_W){sign_ext & half_sel[HALF_W-1]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   RV32I load/store unit initiator driving a word-wide, synchronous-read,
//   word-write data memory. Sub-word stores are performed as
//   read-modify-write; loads are lane-extracted and extended.
//   Ports:
//     clk, reset_n          - clock, asynchronous active-low reset
//     req_valid/req_ready   - request handshake (ready only in IDLE)
//     req_we, req_funct3    - store flag and RV32I funct3
//     req_addr, req_wdata   - byte address, right-justified store data
//     resp_valid            - one-cycle completion pulse
//     resp_rdata/resp_fault - extended load data / access rejected
//     mem_we, mem_addr      - word write enable, word-aligned address
//     mem_wdata, mem_rdata  - write word, registered read word
//   Macro LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword and word
//   accesses fault; otherwise they are silently aligned down.
module lsu_mem_master
    import riscv_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [31:0] merged_q, merged_d;

    logic [31:0] load_data;
    logic [31:0] merge_word;
    logic        funct3_bad;
    logic        misalign;
    logic        req_fault;

    // Illegal encodings fault in every build
    always_comb begin
        if (req_we) begin
            funct3_bad = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
        end else begin
            funct3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_fault = funct3_bad | misalign;

    lsu_load_align u_load_align (
        .word_i    (mem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (load_data)
    );

    // Replace the addressed byte/half lane of the word just read
    always_comb begin
        merge_word = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            merge_word[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
        end else begin
            merge_word[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q[HALF_W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        f3_d     = f3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        merged_d = merged_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    fault_d = req_fault;
                    if (req_fault) begin
                        state_d = ST_DONE;
                    end else if (req_we && (req_funct3 != F3_W)) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            // Load: address presented now, data arrives next cycle.
            // SW: write happens at the end of this cycle.
            ST_ISSUE:     state_d = we_q ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: begin
                rdata_d = load_data;
                state_d = ST_DONE;
            end
            ST_RMW_RD:    state_d = ST_RMW_MERGE;
            ST_RMW_MERGE: begin
                merged_d = merge_word;
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR:    state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Merged word is only observed in RMW_WR, so it needs no reset
    always_ff @(posedge clk) begin
        merged_q <= merged_d;
    end

    // Write enable is a pure state decode so an async reset drops it at once
    assign mem_we     = ((state_q == ST_ISSUE) && we_q) || (state_q == ST_RMW_WR);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = (state_q == ST_RMW_WR) ? merged_q : wdata_q;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_fault = (state_q == ST_DONE) && fault_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        flt;
    } exp_t;
    exp_t sb_q[$];

    // Memory model: synchronous read, whole-word write, bench preload port
    logic [31:0] mem [0:63];
    logic        tb_wr_en = 1'b0;
    logic [5:0]  tb_wr_idx = 6'd0;
    logic [31:0] tb_wr_data = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    lsu_mem_master dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every response must match the oldest expectation
    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (sb_q.size() == 0) begin
                chk(32'd1, 32'd0, "unexpected_resp");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk(resp_rdata, e.rd, "resp_rdata");
                chk({31'd0, resp_fault}, {31'd0, e.flt}, "resp_fault");
            end
        end
    end

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        tb_wr_en = 1'b1;
        tb_wr_idx = idx[5:0];
        tb_wr_data = data;
        @(posedge clk);
        #1 tb_wr_en = 1'b0;
    endtask

    // Issue one request; exp_we_idx is the negedge (counted from accept) at
    // which the single mem_we pulse is expected, or -1 for no write.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_flt,
                          input int exp_lat, input int exp_we_idx, input string tag);
        int n, lat, we_n, we_idx;
        bit seen;
        @(negedge clk);
        chk({31'd0, req_ready}, 32'd1, {tag, "_ready"});
        chk({31'd0, resp_valid}, 32'd0, {tag, "_idle_novalid"});
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        sb_q.push_back('{rd: exp_rd, flt: exp_flt});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom;
        req_wdata = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        req_we = ~we;
        n = 0; lat = 0; we_n = 0; we_idx = -1; seen = 0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (mem_we) begin
                we_n++;
                if (we_idx < 0) we_idx = n;
            end
            if (n == 1 && !exp_flt) chk(mem_addr, addr & 32'hFFFF_FFFC, {tag, "_mem_addr"});
            if (resp_valid) begin
                seen = 1;
                lat = n;
            end
        end
        chk({31'd0, seen}, 32'd1, {tag, "_resp_seen"});
        chk(lat, exp_lat, {tag, "_latency"});
        chk(we_n, (exp_we_idx < 0) ? 0 : 1, {tag, "_we_count"});
        chk(we_idx, exp_we_idx, {tag, "_we_cycle"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk({31'd0, req_ready}, 32'd1, "rst_ready");
        chk({31'd0, resp_valid}, 32'd0, "rst_resp_valid");
        chk({31'd0, resp_fault}, 32'd0, "rst_resp_fault");
        chk(resp_rdata, 32'd0, "rst_resp_rdata");
        chk({31'd0, mem_we}, 32'd0, "rst_mem_we");
        chk(mem_addr, 32'd0, "rst_mem_addr");
        chk(mem_wdata, 32'd0, "rst_mem_wdata");
        reset_n = 1'b1;

        poke(4, 32'hDEAD_BEEF);
        poke(8, 32'h1122_3344);
        poke(1, 32'h5566_7788);
        poke(9, 32'h0102_0304);

        // LW
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, -1, "lw");

        // Sub-word loads over 0x80FF_0000
        poke(4, 32'h80FF_0000);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 3, -1, "lb13");
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 3, -1, "lbu13");
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_80FF, 1'b0, 3, -1, "lh12");
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_80FF, 1'b0, 3, -1, "lhu12");
        do_req(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FFFF, 1'b0, 3, -1, "lb12");
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_0000, 1'b0, 3, -1, "lbu11");
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_0000, 1'b0, 3, -1, "lhu10");

        // SB read-modify-write
        do_req(1'b1, 3'b000, 32'h21, 32'hFFFF_FFAA, 32'h0, 1'b0, 4, 3, "sb21");
        chk(mem[8], 32'h1122_AA44, "sb21_mem");

        // SH at odd halfword address
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b1, 3'b001, 32'h06, 32'h1234_BEEF, 32'h0, 1'b1, 1, -1, "sh06");
        chk(mem[1], 32'h5566_7788, "sh06_mem");
`else
        do_req(1'b1, 3'b001, 32'h06, 32'h1234_BEEF, 32'h0, 1'b0, 4, 3, "sh06");
        chk(mem[1], 32'hBEEF_7788, "sh06_mem");
`endif

        // SW
        do_req(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1, "sw30");
        chk(mem[12], 32'hCAFE_F00D, "sw30_mem");

        // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, 3'b010, 32'h32, 32'h0, 32'h0, 1'b1, 1, -1, "lw32");
`else
        do_req(1'b0, 3'b010, 32'h32, 32'h0, 32'hCAFE_F00D, 1'b0, 3, -1, "lw32");
`endif

        // Illegal funct3
        do_req(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1, -1, "ld_f3_111");
        do_req(1'b1, 3'b011, 32'h30, 32'h5555_5555, 32'h0, 1'b1, 1, -1, "st_f3_011");
        chk(mem[12], 32'hCAFE_F00D, "st_f3_011_mem");

        // Reset during RMW_MERGE of an SB
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h24;
        req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk({31'd0, mem_we}, 32'd0, "abort_mem_we");
        chk({31'd0, resp_valid}, 32'd0, "abort_resp_valid");
        chk({31'd0, req_ready}, 32'd1, "abort_ready");
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({30'd0, mem_we, resp_valid}, 32'd0, "abort_hold_quiet");
        end
        req_valid = 1'b0;
        reset_n = 1'b1;
        chk(mem[9], 32'h0102_0304, "abort_mem");
        do_req(1'b0, 3'b010, 32'h24, 32'h0, 32'h0102_0304, 1'b0, 3, -1, "lw_after_abort");

        @(negedge clk);
        chk(sb_q.size(), 32'd0, "scoreboard_empty");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
